// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU: add, iterative mul, cmp, rsh, lsh
//
// Purpose: registered, multi-cycle successor to the combinational datapath ALU.
//   Requests are accepted on in_valid && in_ready. Multiply runs WIDTH shift-add
//   iterations. Each result is held in DONE until out_ready is seen.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake; opcode/op1/op2 are captured on accept
//   out_valid/out_ready result handshake
//   dout               registered result (WIDTH bits)
//   eflags             {ZERO, NEG, OVERFLOW, CARRY}; sticky, written only on entry to DONE
//   illegal            the current result belongs to an illegal opcode
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       eflags,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
  localparam logic [OPW-1:0] OP_CMP = OPW'(3);
  localparam logic [OPW-1:0] OP_RSH = OPW'(4);
  localparam logic [OPW-1:0] OP_LSH = OPW'(5);
  localparam int ITW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic             last_iter;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]   hi_sum;
  logic [ITW-1:0]   iter;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_ill;
  logic [3:0]       mul_flags;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   rsh_full;
  logic [WIDTH:0]   lsh_full;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (opcode == OP_MUL);
  assign last_iter = (iter == ITW'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul ? MUL : DONE;
      MUL:  if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Multiplier held in acc's low half and consumed LSB first; each step adds the
  // multiplicand into the high half and shifts the whole accumulator right, so the
  // add's carry drops into the top bit.
  assign hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_step = {hi_sum, acc[WIDTH-1:1]};

  assign mul_flags[0] = |acc_step[2*WIDTH-1:WIDTH];
  assign mul_flags[1] = |acc_step[2*WIDTH-1:WIDTH];
  assign mul_flags[2] = acc_step[WIDTH-1];
  assign mul_flags[3] = (acc_step[WIDTH-1:0] == '0);

  // Single-cycle ops, evaluated on the live request inputs at the accept edge.
  // The shifts carry one extra bit so the last bit shifted out lands in it;
  // oversized shift amounts naturally flush everything to zero.
  assign add_full = {1'b0, op1} + {1'b0, op2};
  assign sub_full = {1'b0, op1} - {1'b0, op2};
  assign rsh_full = {op1, 1'b0} >> op2;
  assign lsh_full = {1'b0, op1} << op2;

  always_comb begin
    alu_res   = '0;
    alu_flags = eflags;
    alu_ill   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res      = add_full[WIDTH-1:0];
        alu_flags[0] = add_full[WIDTH];
        alu_flags[1] = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_full[WIDTH-1] != op1[WIDTH-1]);
        alu_flags[2] = add_full[WIDTH-1];
        alu_flags[3] = (add_full[WIDTH-1:0] == '0);
      end
      OP_CMP: begin
        alu_res      = '0;
        alu_flags[0] = sub_full[WIDTH];
        alu_flags[1] = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_full[WIDTH-1] != op1[WIDTH-1]);
        alu_flags[2] = sub_full[WIDTH-1];
        alu_flags[3] = (op1 == op2);
      end
      OP_RSH: begin
        alu_res      = rsh_full[WIDTH:1];
        alu_flags[0] = rsh_full[0];
        alu_flags[1] = 1'b0;
        alu_flags[2] = rsh_full[WIDTH];
        alu_flags[3] = (rsh_full[WIDTH:1] == '0);
      end
      OP_LSH: begin
        alu_res      = lsh_full[WIDTH-1:0];
        alu_flags[0] = lsh_full[WIDTH];
        alu_flags[1] = 1'b0;
        alu_flags[2] = lsh_full[WIDTH-1];
        alu_flags[3] = (lsh_full[WIDTH-1:0] == '0);
      end
      OP_MUL: ;
      default: alu_ill = 1'b1;  // eflags kept, dout cleared
    endcase
  end

  // ---------------- multiply datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      iter  <= '0;
    end else if (accept) begin
      mcand <= op1;
      acc   <= {{WIDTH{1'b0}}, op2};
      iter  <= '0;
    end else if (state == MUL) begin
      acc   <= acc_step;
      iter  <= iter + ITW'(1);
    end
  end

  // ---------------- result registers (written only on entry to DONE) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      eflags  <= 4'b0000;
      illegal <= 1'b0;
    end else if (state == IDLE && accept && !is_mul) begin
      dout    <= alu_res;
      eflags  <= alu_flags;
      illegal <= alu_ill;
    end else if (state == MUL && last_iter) begin
      dout    <= acc_step[WIDTH-1:0];
      eflags  <= mul_flags;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed table-driven bench for alu_seq
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] opcode;
  logic [7:0] op1;
  logic [7:0] op2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic [3:0] eflags;
  logic       illegal;

  int n_vec  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(8), .OPW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .eflags(eflags), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic [3:0] exp_f;
    logic       exp_ill;
    int         exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready=1 and check result, flags and latency.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, ".in_ready"}, int'(in_ready), 1);
    in_valid  = 1'b1;
    opcode    = v.opc;
    op1       = v.a;
    op2       = v.b;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) begin
        chk({tag, ".busy_in_ready"}, int'(in_ready), 0);
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, v.exp_lat);
    chk({tag, ".dout"}, int'(dout), int'(v.exp_d));
    chk({tag, ".eflags"}, int'(eflags), int'(v.exp_f));
    chk({tag, ".illegal"}, int'(illegal), int'(v.exp_ill));
    @(negedge clk);  // handshake-out happened on the edge in between
    chk({tag, ".back_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    int cyc;
    bit seen;

    vecs[0]  = '{8'h01, 8'h7F, 8'h01, 8'h80, 4'b0110, 1'b0, 1};
    vecs[1]  = '{8'h01, 8'hFF, 8'h01, 8'h00, 4'b1001, 1'b0, 1};
    vecs[2]  = '{8'h03, 8'h05, 8'h05, 8'h00, 4'b1000, 1'b0, 1};
    vecs[3]  = '{8'h03, 8'h03, 8'h05, 8'h00, 4'b0101, 1'b0, 1};
    vecs[4]  = '{8'h02, 8'h10, 8'h10, 8'h00, 4'b1011, 1'b0, 9};
    vecs[5]  = '{8'h02, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b0, 9};
    vecs[6]  = '{8'h05, 8'h81, 8'h01, 8'h02, 4'b0001, 1'b0, 1};
    vecs[7]  = '{8'h04, 8'h81, 8'h09, 8'h00, 4'b1000, 1'b0, 1};
    vecs[8]  = '{8'h04, 8'h81, 8'h00, 8'h81, 4'b0100, 1'b0, 1};
    vecs[9]  = '{8'h01, 8'hFF, 8'h01, 8'h00, 4'b1001, 1'b0, 1};
    vecs[10] = '{8'h07, 8'h12, 8'h34, 8'h00, 4'b1001, 1'b1, 1};
    vecs[11] = '{8'h00, 8'h55, 8'h66, 8'h00, 4'b1001, 1'b1, 1};
    vecs[12] = '{8'h01, 8'h80, 8'h80, 8'h00, 4'b1011, 1'b0, 1};
    vecs[13] = '{8'h05, 8'h81, 8'h08, 8'h00, 4'b1001, 1'b0, 1};
    vecs[14] = '{8'h04, 8'h81, 8'h08, 8'h00, 4'b1001, 1'b0, 1};
    vecs[15] = '{8'h02, 8'hFF, 8'hFF, 8'h01, 4'b0011, 1'b0, 9};
    vecs[16] = '{8'h03, 8'h80, 8'h01, 8'h00, 4'b0010, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.dout", int'(dout), 0);
    chk("rst.eflags", int'(eflags), 0);
    chk("rst.illegal", int'(illegal), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Backpressure: 0x01+0x01 held in DONE, a competing request must be ignored.
    @(negedge clk);
    in_valid = 1'b1; opcode = 8'h01; op1 = 8'h01; op2 = 8'h01; out_ready = 1'b0;
    @(negedge clk);
    opcode = 8'h01; op1 = 8'hFF; op2 = 8'h01;  // held while not ready
    for (int k = 0; k < 5; k++) begin
      chk("bp.out_valid", int'(out_valid), 1);
      chk("bp.in_ready", int'(in_ready), 0);
      chk("bp.dout", int'(dout), 8'h02);
      chk("bp.eflags", int'(eflags), 4'b0000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_in_ready", int'(in_ready), 1);
    chk("bp.release_out_valid", int'(out_valid), 0);
    chk("bp.release_dout", int'(dout), 8'h02);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp.no_extra_result", int'(out_valid), 0);

    // Reset during the 4th multiply iteration.
    in_valid = 1'b1; opcode = 8'h02; op1 = 8'h0D; op2 = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst.busy", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", int'(in_ready), 1);
    chk("mrst.out_valid", int'(out_valid), 0);
    chk("mrst.eflags", int'(eflags), 0);
    chk("mrst.dout", int'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (cyc < 15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      cyc++;
    end
    chk("mrst.no_result", int'(seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
